conv_mac_row: RTL and testbench

Six-lane signed multiply-accumulate row that consumes the staggered weight stream produced by the convolution weight fetch stage. One activation stream enters lane 0 and ripples one lane per cycle, so lane k pairs weight k with the activation of k cycles earlier. Each lane accumulates over its enable window. Finished partial sums are queued and drained one per cycle over a valid/ready port to the downstream accumulation/output stage.

---
 rtl/conv_pkg.sv | 8 +
 rtl/conv_mac_lane.sv | 98 +++++++++
 rtl/conv_mac_row.sv | 131 +++++++++++++
 tb/tb_conv_mac_row.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution MAC row.
package conv_pkg;
  localparam int LANES  = 6;
  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef logic [2:0] lane_t;
endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: window start/end detect, accumulator, result hold and
// pending flag. Build option CONV_MAC_SAT_EN clamps each accumulate and
// exposes a sticky o_sat flag; otherwise the accumulator wraps.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en_cur,
  input  logic                     i_en_prev,
  input  logic signed [DATA_W-1:0] i_act,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic                     i_drain,
  output logic                     o_pend,
  output logic [ACC_W-1:0]         o_hold,
  output logic                     o_ovr
`ifdef CONV_MAC_SAT_EN
  ,
  output logic                     o_sat
`endif
);

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_x, acc_q, acc_d, hold_q;
  logic                     pend_q, win_start, win_acc, win_end;

  assign prod      = i_w * i_act;
  assign prod_x    = ACC_W'(prod);
  assign win_start = i_en_cur & ~i_en_prev;
  assign win_acc   = i_en_cur & i_en_prev;
  assign win_end   = ~i_en_cur & i_en_prev;

`ifdef CONV_MAC_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           ovf, sat_q;

  assign sum_w = {acc_q[ACC_W-1], acc_q} + {prod_x[ACC_W-1], prod_x};
  assign ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

  // Next accumulator: restart on window start, clamped add inside window.
  always_comb begin
    acc_d = acc_q;
    if (win_start)
      acc_d = prod_x;
    else if (win_acc)
      acc_d = ovf ? (sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                  : sum_w[ACC_W-1:0];
  end

  // Sticky clamp flag; only reset clears it, flush does not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sat_q <= 1'b0;
    else          sat_q <= sat_q | (win_acc & ovf & ~i_clr);
  end

  assign o_sat = sat_q;
`else
  logic [ACC_W-1:0] sum_w;

  assign sum_w = acc_q + prod_x;

  // Next accumulator: restart on window start, wrapping add inside window.
  always_comb begin
    acc_d = acc_q;
    if (win_start)    acc_d = prod_x;
    else if (win_acc) acc_d = sum_w;
  end
`endif

  // Accumulator, hold and pending state; completion beats a same-edge drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      hold_q <= '0;
      pend_q <= 1'b0;
    end else if (i_clr) begin
      acc_q  <= '0;
      hold_q <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (win_end) begin
        hold_q <= acc_q;
        pend_q <= 1'b1;
      end else if (i_drain) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign o_pend = pend_q;
  assign o_hold = hold_q;
  assign o_ovr  = win_end & pend_q & ~i_clr;

endmodule

// File: rtl/conv_mac_row.sv
// Six-lane signed MAC row. Owns the enable/activation ripple pipelines,
// lowest-index-first result select and the valid/ready output register.
// Optional build macro: CONV_MAC_SAT_EN (saturating lanes plus o_sat).
module conv_mac_row
  import conv_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_data_en,
  input  logic [DATA_W-1:0] i_act,
  input  logic [DATA_W-1:0] i_w0,
  input  logic [DATA_W-1:0] i_w1,
  input  logic [DATA_W-1:0] i_w2,
  input  logic [DATA_W-1:0] i_w3,
  input  logic [DATA_W-1:0] i_w4,
  input  logic [DATA_W-1:0] i_w5,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [2:0]        o_lane,
  output logic [ACC_W-1:0]  o_psum,
  output logic              o_busy,
  output logic              o_err
`ifdef CONV_MAC_SAT_EN
  ,
  output logic              o_sat
`endif
);

  logic [LANES:1]                 en_q;
  logic [LANES:0]                 en;
  logic [LANES-1:1][DATA_W-1:0]   act_q;
  logic [LANES-1:0][DATA_W-1:0]   act, w;
  logic [LANES-1:0]               pend, drain, ovr;
  logic [LANES-1:0][ACC_W-1:0]    hold;
  logic                           sel_vld, load;
  lane_t                          sel;
  logic                           valid_q, err_q;
  lane_t                          lane_q;
  logic [ACC_W-1:0]               psum_q;

  assign en  = {en_q, i_data_en};
  assign act = {act_q, i_act};
  assign w   = {i_w5, i_w4, i_w3, i_w2, i_w1, i_w0};

  // Enable and activation ripple one lane per cycle; flush kills open windows.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q  <= '0;
      act_q <= '0;
    end else begin
      en_q  <= i_clr ? '0 : en[LANES-1:0];
      act_q <= act[LANES-2:0];
    end
  end

`ifdef CONV_MAC_SAT_EN
  logic [LANES-1:0] lane_sat;
  assign o_sat = |lane_sat;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    conv_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (i_clr),
      .i_en_cur  (en[k]),
      .i_en_prev (en[k+1]),
      .i_act     (act[k]),
      .i_w       (w[k]),
      .i_drain   (drain[k]),
      .o_pend    (pend[k]),
      .o_hold    (hold[k]),
      .o_ovr     (ovr[k])
`ifdef CONV_MAC_SAT_EN
      ,
      .o_sat     (lane_sat[k])
`endif
    );
  end

  // Lowest-index pending lane wins the output slot.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_vld = 1'b1;
        sel     = lane_t'(k);
      end
    end
  end

  assign load = ~valid_q | i_ready;

  // One-hot drain back to the selected lane when the slot reloads.
  always_comb begin
    drain = '0;
    if (load && sel_vld) drain[sel] = 1'b1;
  end

  // Output slot and sticky overrun flag; flush empties the slot only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      lane_q  <= '0;
      psum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | (|ovr);
      if (i_clr) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= sel_vld;
        if (sel_vld) begin
          lane_q <= sel;
          psum_q <= hold[sel];
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_lane  = lane_q;
  assign o_psum  = psum_q;
  assign o_err   = err_q;
  assign o_busy  = (|en) | (|pend) | valid_q;

endmodule

// File: tb/tb_conv_mac_row.sv
// Self-checking bench for conv_mac_row: a 20-bit and a 16-bit instance
// share stimulus; a cycle-indexed history model predicts every output.
module tb_conv_mac_row;

`ifdef CONV_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int NH = 8192;

  logic       clk = 1'b0;
  logic       rst_n, clr, den, ready;
  logic [7:0] act;
  logic [7:0] w [6];

  logic        v20, b20, e20, v16, b16, e16;
  logic [2:0]  l20, l16;
  logic [19:0] p20;
  logic [15:0] p16;
  logic        s20, s16;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  conv_mac_row #(.ACC_W(20)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_data_en(den), .i_act(act),
    .i_w0(w[0]), .i_w1(w[1]), .i_w2(w[2]), .i_w3(w[3]), .i_w4(w[4]), .i_w5(w[5]),
    .i_ready(ready), .o_valid(v20), .o_lane(l20), .o_psum(p20), .o_busy(b20),
    .o_err(e20)
`ifdef CONV_MAC_SAT_EN
    , .o_sat(s20)
`endif
  );

  conv_mac_row #(.ACC_W(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_data_en(den), .i_act(act),
    .i_w0(w[0]), .i_w1(w[1]), .i_w2(w[2]), .i_w3(w[3]), .i_w4(w[4]), .i_w5(w[5]),
    .i_ready(ready), .o_valid(v16), .o_lane(l16), .o_psum(p16), .o_busy(b16),
    .o_err(e16)
`ifdef CONV_MAC_SAT_EN
    , .o_sat(s16)
`endif
  );

`ifndef CONV_MAC_SAT_EN
  assign s20 = 1'b0;
  assign s16 = 1'b0;
`endif

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         hen  [NH];
  logic [7:0] hact [NH];
  int         cyc = 0, epoch = 0;
  int         AW [2] = '{20, 16};
  longint     macc [2][6], mhold [2][6], mopsum [2];
  bit         mpend [6], oldp [6];
  bit         mov, merr;
  bit         msat [2];
  int         mlane;

  function automatic bit en_at(int t);
    return (t >= epoch && t >= 0) ? hen[t % NH] : 1'b0;
  endfunction

  function automatic longint wrapw(longint s, int wd);
    longint m = longint'(1) << wd;
    longint r = s % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Model update per edge: drain decision from pre-edge state, then lanes.
  always @(posedge clk or negedge rst_n) begin : model
    int t, j;
    bit cur, prv;
    longint p, s, mx, mn;
    if (!rst_n) begin
      foreach (mpend[k]) mpend[k] = 0;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 6; k++) begin macc[i][k] = 0; mhold[i][k] = 0; end
        mopsum[i] = 0; msat[i] = 0;
      end
      mov = 0; merr = 0; mlane = 0; epoch = cyc;
    end else begin
      t = cyc;
      hen[t % NH] = den; hact[t % NH] = act;
      if (clr) begin
        foreach (mpend[k]) mpend[k] = 0;
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < 6; k++) begin macc[i][k] = 0; mhold[i][k] = 0; end
        mov = 0; epoch = t + 1;
      end else begin
        foreach (mpend[k]) oldp[k] = mpend[k];
        if (!mov || ready) begin
          j = -1;
          for (int k = 5; k >= 0; k--) if (mpend[k]) j = k;
          if (j >= 0) begin
            mov = 1; mlane = j; mpend[j] = 0;
            for (int i = 0; i < 2; i++) mopsum[i] = mhold[i][j];
          end else mov = 0;
        end
        for (int k = 0; k < 6; k++) begin
          cur = en_at(t - k); prv = en_at(t - k - 1);
          if (cur) p = longint'($signed(w[k])) * longint'($signed(hact[(t - k) % NH]));
          else     p = 0;
          for (int i = 0; i < 2; i++) begin
            if (cur && !prv) macc[i][k] = p;
            else if (cur && prv) begin
              s  = macc[i][k] + p;
              mx = (longint'(1) << (AW[i] - 1)) - 1;
              mn = -(longint'(1) << (AW[i] - 1));
              if (SAT) begin
                if (s > mx) begin s = mx; msat[i] = 1; end
                if (s < mn) begin s = mn; msat[i] = 1; end
                macc[i][k] = s;
              end else macc[i][k] = wrapw(s, AW[i]);
            end else if (!cur && prv) mhold[i][k] = macc[i][k];
          end
          if (!cur && prv) begin
            if (oldp[k]) merr = 1;
            mpend[k] = 1;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  int     got_lane [$], got_cyc [$];
  longint got20 [$], got16 [$];

  always @(negedge clk) begin : cmp
    bit mbusy;
    if (rst_n) begin
      mbusy = den | mov;
      for (int j = 1; j <= 6; j++) mbusy |= en_at(cyc - j);
      foreach (mpend[k]) mbusy |= mpend[k];
      check("valid20", v20, mov);
      check("valid16", v16, mov);
      check("busy20", b20, mbusy);
      check("busy16", b16, mbusy);
      check("err20", e20, merr);
      check("err16", e16, merr);
      if (SAT) begin
        check("sat20", s20, msat[0]);
        check("sat16", s16, msat[1]);
      end
      if (mov) begin
        check("lane20", l20, mlane);
        check("lane16", l16, mlane);
        check("psum20", longint'($signed(p20)), mopsum[0]);
        check("psum16", longint'($signed(p16)), mopsum[1]);
      end
      if (v20 && ready) begin
        got_lane.push_back(int'(l20));
        got20.push_back(longint'($signed(p20)));
        got16.push_back(longint'($signed(p16)));
        got_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_got();
    got_lane.delete(); got20.delete(); got16.delete(); got_cyc.delete();
  endtask

  task automatic drain_all();
    int n = 0;
    ready = 1'b1;
    den   = 1'b0;
    while ((b20 || b16) && n < 60) begin tick(1); n++; end
    if (n >= 60) check("drain_timeout", 1, 0);
    tick(1);
  endtask

  task automatic set_w(input int base, input int step);
    for (int k = 0; k < 6; k++) w[k] = 8'(base + step * k);
  endtask

  task automatic window3();
    den = 1'b1; act = 8'd1; tick(1);
    act = 8'd2; tick(1);
    act = 8'd3; tick(1);
    den = 1'b0; act = 8'd0;
  endtask

  task automatic check_ordered(input string tag);
    check({tag, "_count"}, got_lane.size(), 6);
    for (int i = 0; i < 6 && i < got_lane.size(); i++) begin
      check({tag, "_lane"}, got_lane[i], i);
      check({tag, "_sum20"}, got20[i], 6 * (i + 1));
      check({tag, "_sum16"}, got16[i], 6 * (i + 1));
    end
  endtask

  initial begin
    int t0, n0;
    longint l0 [$];
    rst_n = 1'b0; clr = 1'b0; den = 1'b0; act = '0; ready = 1'b0;
    set_w(0, 0);
    tick(3);
    check("rst_valid", v20, 0);
    check("rst_busy", b20, 0);
    check("rst_err", e20, 0);
    check("rst_psum", p20, 0);
    check("rst_lane", l20, 0);
    rst_n = 1'b1;
    tick(2);

    // sum ordering with ready held high
    clear_got(); ready = 1'b1; set_w(1, 1);
    window3();
    t0 = cyc;
    drain_all();
    check_ordered("order");
    if (got_cyc.size() == 6) begin
      check("order_lat", got_cyc[0] - t0, 2);
      for (int i = 1; i < 6; i++) check("order_consec", got_cyc[i] - got_cyc[i-1], 1);
    end

    // backpressure: stall, verify held result, then release
    clear_got(); ready = 1'b0;
    window3();
    tick(10);
    check("stall_valid", v20, 1);
    check("stall_lane", l20, 0);
    check("stall_psum", p20, 6);
    tick(3);
    check("stall_psum_hold", p20, 6);
    check("stall_err", e20, 0);
    drain_all();
    check_ordered("bp");

    // signed extreme product
    clear_got(); set_w(0, 0); w[0] = 8'd127;
    den = 1'b1; act = 8'h80; tick(1);
    den = 1'b0; act = '0;
    drain_all();
    if (got_lane.size() > 0) begin
      check("signed_lane", got_lane[0], 0);
      check("signed_sum20", got20[0], -16256);
      check("signed_sum16", got16[0], -16256);
    end else check("signed_count", got_lane.size(), 6);

    // width limit on the 16-bit instance
    clear_got(); set_w(127, 0);
    den = 1'b1; act = 8'd127; tick(3);
    den = 1'b0; act = '0;
    drain_all();
    if (got_lane.size() > 0) begin
      check("width_sum20", got20[0], 48387);
      check("width_sum16", got16[0], SAT ? 32767 : -17149);
    end else check("width_count", got_lane.size(), 6);
    if (SAT) begin
      check("width_sat16", s16, 1);
      check("width_sat20", s20, 0);
    end

    // overrun: lane 0 window 2 still pending when window 3 ends
    clear_got(); set_w(1, 0);
    check("ovr_err_before", e20, 0);
    ready = 1'b0;
    den = 1'b1; act = 8'd1; tick(1); den = 1'b0; tick(1);
    den = 1'b1; act = 8'd2; tick(1); den = 1'b0; tick(1);
    den = 1'b1; act = 8'd3; tick(1); den = 1'b0; act = '0;
    tick(8);
    check("ovr_err20", e20, 1);
    check("ovr_err16", e16, 1);
    drain_all();
    l0.delete();
    foreach (got_lane[i]) if (got_lane[i] == 0) l0.push_back(got20[i]);
    check("ovr_l0_count", l0.size(), 2);
    if (l0.size() == 2) begin
      check("ovr_l0_first", l0[0], 1);
      check("ovr_l0_last", l0[1], 3);
    end

    // flush mid-window, then a fresh window
    ready = 1'b1; set_w(1, 0);
    den = 1'b1; act = 8'd5; tick(2);
    clr = 1'b1; den = 1'b0; tick(1);
    clr = 1'b0;
    check("clr_valid", v20, 0);
    check("clr_busy", b20, 0);
    clear_got();
    den = 1'b1; act = 8'd1; tick(1); den = 1'b0; act = '0;
    drain_all();
    check("clr_count", got_lane.size(), 6);
    foreach (got20[i]) check("clr_fresh", got20[i], 1);

    // reset mid-window, then a fresh window
    den = 1'b1; act = 8'd7; tick(2);
    rst_n = 1'b0; den = 1'b0; tick(1);
    check("rstw_valid", v20, 0);
    check("rstw_busy", b20, 0);
    check("rstw_err", e20, 0);
    rst_n = 1'b1; tick(1);
    clear_got();
    den = 1'b1; act = 8'd2; tick(1); den = 1'b0; act = '0;
    drain_all();
    check("rstw_count", got_lane.size(), 6);
    foreach (got20[i]) check("rstw_fresh", got20[i], 2);

    // randomized traffic against the model
    n0 = 0;
    for (int i = 0; i < 3000; i++) begin
      den   = ($urandom_range(0, 3) != 0);
      act   = 8'($urandom);
      for (int k = 0; k < 6; k++) w[k] = 8'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 299) == 0);
      if (clr) n0++;
      tick(1);
    end
    clr = 1'b0;
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
